// File: rtl/nn_operand_sel.sv
// N-channel operand selector with a registered valid/ready output and a snapshot sweep mode.
// Optional out-of-range error reporting is enabled by defining NN_OPERAND_SEL_ERR_EN.
module nn_operand_sel #(
  parameter int WIDTH    = 14,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      start,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      sel_err
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0]          data_q, data_d;
  logic [SEL_W-1:0]          ch_q, ch_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;

  logic                      slot_free;
  logic                      accept;
  logic                      sel_ok;
  logic [WIDTH-1:0]          dir_word;
  logic [WIDTH-1:0]          sweep_word;

  assign slot_free = !valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && !start && slot_free;
  assign accept    = in_valid && in_ready;
  assign sel_ok    = (int'(sel) < CHANNELS);

  // Explicit compare-mux so an out-of-range index yields zero rather than X.
  always_comb begin
    dir_word   = '0;
    sweep_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k))   dir_word   = in_data[k*WIDTH +: WIDTH];
      if (cnt_q == SEL_W'(k)) sweep_word = snap_q[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    data_d  = data_q;
    ch_d    = ch_q;
    last_d  = last_q;
    valid_d = valid_q && !out_ready;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = in_data;
          cnt_d   = '0;
          state_d = SWEEP;
        end else if (accept) begin
          if (sel_ok) begin
            data_d  = dir_word;
            ch_d    = sel;
            last_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
`ifdef NN_OPERAND_SEL_ERR_EN
            err_d   = 1'b1;
`else
            data_d  = '0;
            ch_d    = sel;
            last_d  = 1'b0;
            valid_d = 1'b1;
`endif
          end
        end
      end
      SWEEP: begin
        if (slot_free) begin
          data_d  = sweep_word;
          ch_d    = cnt_q;
          last_d  = (cnt_q == LAST_CH);
          valid_d = 1'b1;
          if (cnt_q == LAST_CH) state_d = IDLE;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == SWEEP);
  assign sel_err   = err_q;

endmodule

// File: tb/tb_nn_operand_sel.sv
// Bench for nn_operand_sel: directed scenarios plus a randomized run against a queue-based model.
module tb_nn_operand_sel;
  localparam int WIDTH    = 14;
  localparam int CHANNELS = 3;
  localparam int SEL_W    = 2;
  localparam int DW       = CHANNELS * WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] ch;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [DW-1:0]    in_data = '0;
  logic [SEL_W-1:0] sel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             start = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             sel_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] base_data;
  assign base_data = {14'h3FFF, 14'h2AAA, 14'h0011};

  always #5 clk = ~clk;

  nn_operand_sel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .sel_err(sel_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_data, out_ch, out_last, out_valid, busy, sel_err} !== '0) begin
      errors++;
      $display("FAIL reset_async: got data=%h ch=%0d last=%b valid=%b busy=%b err=%b, want all 0",
               out_data, out_ch, out_last, out_valid, busy, sel_err);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({out_data, out_ch, out_last, out_valid, busy, sel_err, in_ready} !== {{(WIDTH+SEL_W+4){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: got valid=%b busy=%b err=%b in_ready=%b, want 0 0 0 1",
               out_valid, busy, sel_err, in_ready);
    end
  endtask

  task automatic test_direct();
    in_data = base_data;
    out_ready = 1'b1;
    sel = 2'd2;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL direct_in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_last, out_ch, out_data} !== {1'b1, 1'b0, 2'd2, 14'h3FFF}) begin
      errors++;
      $display("FAIL direct_beat: got v=%b l=%b ch=%0d d=%h want v=1 l=0 ch=2 d=3fff",
               out_valid, out_last, out_ch, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL direct_consumed: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] exp_d;
    int busy_cycles;
    in_data = base_data;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int k = 0; k < CHANNELS; k++) begin
      tick();
      exp_d = base_data[k*WIDTH +: WIDTH];
      checks++;
      if ({out_valid, out_ch, out_data, out_last} !== {1'b1, SEL_W'(k), exp_d, (k == CHANNELS-1)}) begin
        errors++;
        $display("FAIL sweep_beat%0d: got v=%b ch=%0d d=%h l=%b want v=1 ch=%0d d=%h l=%b",
                 k, out_valid, out_ch, out_data, out_last, k, exp_d, (k == CHANNELS-1));
      end
      if (busy) busy_cycles++;
    end
    tick();
    if (busy) busy_cycles++;
    checks++;
    if (busy_cycles !== CHANNELS || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_busy: got busy_cycles=%0d valid=%b want %0d and 0", busy_cycles, out_valid, CHANNELS);
    end
  endtask

  task automatic test_stall_snapshot();
    int bad;
    in_data = base_data;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom(), $urandom()};
      #1;
      if (in_ready !== 1'b0) bad++;
      tick();
      if ({out_valid, out_ch, out_data, out_last} !== {1'b1, 2'd1, 14'h2AAA, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d bad cycles (last v=%b ch=%0d d=%h rdy=%b) want 0",
               bad, out_valid, out_ch, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_ch, out_data, out_last} !== {1'b1, 2'd2, 14'h3FFF, 1'b1}) begin
      errors++;
      $display("FAIL stall_snapshot_beat2: got v=%b ch=%0d d=%h l=%b want v=1 ch=2 d=3fff l=1",
               out_valid, out_ch, out_data, out_last);
    end
    tick();
    in_data = base_data;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL stall_end: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_priority();
    int nb;
    logic [7:0] chs;
    in_data = base_data;
    out_ready = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    sel = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL priority_in_ready: got %b want 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    chs = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        nb++;
        chs = {chs[5:0], out_ch};
      end
      tick();
    end
    checks++;
    if (nb !== 3 || chs !== 8'b00_00_01_10) begin
      errors++;
      $display("FAIL priority_beats: got %0d beats seq=%b want 3 beats seq=00000110", nb, chs);
    end
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    sel = 2'd3;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
`ifdef NN_OPERAND_SEL_ERR_EN
    checks++;
    if ({sel_err, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL oor_err_pulse: got err=%b valid=%b want 1 0", sel_err, out_valid);
    end
    tick();
    checks++;
    if ({sel_err, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL oor_err_end: got err=%b valid=%b want 0 0", sel_err, out_valid);
    end
`else
    checks++;
    if ({out_valid, out_ch, out_data, sel_err} !== {1'b1, 2'd3, 14'h0, 1'b0}) begin
      errors++;
      $display("FAIL oor_beat: got v=%b ch=%0d d=%h err=%b want v=1 ch=3 d=0 err=0",
               out_valid, out_ch, out_data, sel_err);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid_sweep();
    in_data = base_data;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_ch, out_last, out_valid, busy, sel_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_sweep: got d=%h ch=%0d l=%b v=%b busy=%b want all 0",
               out_data, out_ch, out_last, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 14'h0011}) begin
      errors++;
      $display("FAIL restart_after_reset: got v=%b ch=%0d d=%h want v=1 ch=0 d=0011",
               out_valid, out_ch, out_data);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t m;
    logic mv, merr, st, iv, ordy, idle_b, free, exp_rdy;
    logic [SEL_W-1:0] s;
    logic [DW-1:0] d;
    int bad_ctl, bad_out;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mv = 1'b0;
    merr = 1'b0;
    m = '0;
    bad_ctl = 0;
    bad_out = 0;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(7) == 0);
      iv = $urandom_range(1) != 0;
      ordy = ($urandom_range(3) != 0);
      s = SEL_W'($urandom_range(3));
      d = DW'({$urandom(), $urandom()});
      start = st; in_valid = iv; out_ready = ordy; sel = s; in_data = d;
      #1;
      idle_b = (q.size() == 0);
      free = !mv || ordy;
      exp_rdy = idle_b && !st && free;
      checks++;
      if ({in_ready, busy} !== {exp_rdy, !idle_b}) begin
        errors++;
        bad_ctl++;
        if (bad_ctl < 5)
          $display("FAIL rand_ctl cycle %0d: got rdy=%b busy=%b want rdy=%b busy=%b",
                   i, in_ready, busy, exp_rdy, !idle_b);
      end
      tick();
      merr = 1'b0;
      if (free) begin
        if (!idle_b) begin
          m = q.pop_front();
          mv = 1'b1;
        end else if (iv && exp_rdy) begin
          if (int'(s) < CHANNELS) begin
            m = '{d[int'(s)*WIDTH +: WIDTH], s, 1'b0};
            mv = 1'b1;
          end else begin
`ifdef NN_OPERAND_SEL_ERR_EN
            merr = 1'b1;
            mv = 1'b0;
`else
            m = '{'0, s, 1'b0};
            mv = 1'b1;
`endif
          end
        end else begin
          mv = 1'b0;
        end
      end
      if (st && idle_b)
        for (int k = 0; k < CHANNELS; k++)
          q.push_back('{d[k*WIDTH +: WIDTH], SEL_W'(k), (k == CHANNELS-1)});
      checks++;
      if (out_valid !== mv || sel_err !== merr || (mv && {out_data, out_ch, out_last} !== m)) begin
        errors++;
        bad_out++;
        if (bad_out < 5)
          $display("FAIL rand_out cycle %0d: got v=%b d=%h ch=%0d l=%b err=%b want v=%b d=%h ch=%0d l=%b err=%b",
                   i, out_valid, out_data, out_ch, out_last, sel_err, mv, m.d, m.ch, m.last, merr);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_sweep();
    test_stall_snapshot();
    test_priority();
    test_out_of_range();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_operand_sel.md
# nn_operand_sel

Parametrised N-channel operand selector with a registered valid/ready output, feeding operand words to the neural-network datapath's multiply-accumulate stage. It generalises the fixed 3-input, 14-bit combinational selector to any width and channel count. It adds two things that selector lacks: a registered, back-pressurable output, and a sweep mode that streams every channel in order from a one-cycle snapshot. Out-of-range selects are defined, never X.

## Interface
- WIDTH, 14, operand word width in bits.
- CHANNELS, 3, number of input channels, ≥2.
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W ≥ CHANNELS.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  CHANNELS*WIDTH  channel k on bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  channel index for direct requests.
- in_valid  in  1  direct request present.
- in_ready  out  1  direct request accepted this cycle when in_valid is also high.
- start  in  1  single-cycle pulse; begins a sweep.
- out_data  out  WIDTH  selected operand.
- out_ch  out  SEL_W  channel index of out_data.
- out_last  out  1  final beat of a sweep; 0 for direct beats.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream consumes the beat when out_valid is high.
- busy  out  1  sweep in progress.
- sel_err  out  1  one-cycle pulse on an out-of-range direct request (see Configuration).

## Operation
- Two states: IDLE and SWEEP.
- Slot free: the output slot is free when !out_valid || out_ready.
- in_ready: in_ready = IDLE && !start && slot free, computed combinationally. start has priority over in_valid in the same cycle.
- Direct accept (in_valid && in_ready):
  - out_data ← channel sel.
  - out_ch ← sel.
  - out_last ← 0.
  - out_valid ← 1.
- Start in IDLE:
  - Snapshot all of in_data into an internal register.
  - Counter cnt ← 0.
  - Go to SWEEP.
- start while busy: ignored.
- SWEEP, each edge where the slot is free:
  - out_data ← snapshot[cnt], out_ch ← cnt, out_valid ← 1.
  - out_last ← (cnt == CHANNELS-1).
  - If that was the last channel, go to IDLE; otherwise cnt increments.
- SWEEP with the slot not free: hold cnt and all outputs.
- Stall: while out_valid && !out_ready, out_data, out_ch and out_last are held unchanged.
- Beat consumed, no new load: out_valid ← 0.
- busy = (state == SWEEP).
- Out-of-range direct sel (sel ≥ CHANNELS): handled per Configuration. Never X.

## Timing
- Reset values: out_data=0, out_ch=0, out_last=0, out_valid=0, busy=0, sel_err=0, cnt=0, snapshot=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-sweep or mid-stall drops the in-flight beat immediately.
- Direct latency: 1 cycle. A request accepted at edge E has out_valid high after E.
- Sweep latency:
  - start sampled at E0.
  - busy high after E0.
  - Beat k is loaded at E(k+1), assuming out_ready is held high.
  - busy falls after E(CHANNELS), the edge that loads the last beat.
- Throughput: 1 beat/cycle with out_ready held high, in both modes.
- Back-to-back: a new start is accepted the cycle after busy falls. in_ready can be high in that same cycle if the slot is free.
- Input stability: in_data changes during a sweep have no effect. Only the snapshot taken at E0 is used.

## Configuration
- Macro: NN_OPERAND_SEL_ERR_EN.
- Defined:
  - An out-of-range direct request is still accepted (in_ready unaffected).
  - It produces no beat (out_valid unchanged).
  - sel_err pulses high for exactly the cycle after acceptance.
- Undefined:
  - An out-of-range request loads out_data=0, out_ch=sel, out_valid=1.
  - sel_err is tied to 0.

## Test plan
- Reset, direct select: after reset, check every output is 0. Then WIDTH=14, CHANNELS=3, in_data channels {0x0011, 0x2AAA, 0x3FFF}, sel=2, in_valid for one cycle -> next cycle out_data=0x3FFF, out_ch=2, out_valid=1, out_last=0.
- Sweep, no stall: start pulse with out_ready=1 -> three consecutive beats 0x0011, 0x2AAA, 0x3FFF with out_ch 0, 1, 2. out_last high only on the third beat. busy high for exactly 3 cycles.
- Sweep, stall and snapshot: hold out_ready=0 for 4 cycles on beat 1, and change in_data meanwhile -> beat 1 is held stable; beats 1 and 2 are the original snapshot values; in_ready stays 0 throughout.
- Priority: start and in_valid in the same cycle -> in_ready=0 and the sweep runs. Also, start while busy -> ignored, exactly 3 beats total.
- Out-of-range sel=3:
  - With NN_OPERAND_SEL_ERR_EN: sel_err pulses for 1 cycle and out_valid stays 0.
  - Without it: out_data=0, out_ch=3, out_valid=1.
- Reset mid-sweep: drive rst_n low during beat 1 -> all outputs 0 immediately, without waiting for a clock edge. A fresh start after release sweeps from channel 0.
